// File: rtl/branch_resolve_pipe.sv
// ----------------------------------------------------------------------------
// branch_resolve_pipe
//   Resolves one conditional branch per cycle into a single registered result.
//   The result is held until the consumer accepts it. When the output
//   register is freed in a cycle, a new request can refill it in that same
//   cycle, so the block sustains one result per cycle.
//
//   Parameters
//     XLEN  operand / PC / immediate width (8..64)
//     OPW   branch opcode width (>= 3)
//
//   Ports
//     clk, rst_n        clock, asynchronous active-low reset
//     in_valid/in_ready request handshake
//     in_opcode         condition code (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//     in_rs1, in_rs2    compare operands
//     in_pc, in_imm     branch PC and sign-extended offset
//     in_pred_taken     front-end prediction
//     flush             drops the held result and blocks acceptance
//     out_valid/out_ready result handshake
//     out_taken, out_mispredict, out_illegal, out_misaligned, out_target
//
//   Optional feature (macro BRANCH_STATS_EN)
//     stat_branches, stat_taken, stat_mispredict: 32-bit wrapping counters of
//     delivered results. Illegal results are excluded from the taken and
//     mispredict counts.
// ----------------------------------------------------------------------------
module branch_resolve_pipe #(
    parameter int XLEN = 32,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_opcode,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic            out_mispredict,
    output logic            out_illegal,
    output logic            out_misaligned,
    output logic [XLEN-1:0] out_target
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_taken,
    output logic [31:0]     stat_mispredict
`endif
);

    localparam logic [OPW-1:0] OP_BEQ  = OPW'(0);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(1);
    localparam logic [OPW-1:0] OP_BLT  = OPW'(4);
    localparam logic [OPW-1:0] OP_BGE  = OPW'(5);
    localparam logic [OPW-1:0] OP_BLTU = OPW'(6);
    localparam logic [OPW-1:0] OP_BGEU = OPW'(7);

    logic            taken;
    logic            illegal;
    logic            mispredict;
    logic            misaligned;
    logic [XLEN-1:0] target;
    logic            accept;
    logic            deliver;

    // Resolution is purely combinational from the current request, so no
    // value from an earlier request can leak into a new one.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (in_opcode)
            OP_BEQ:  taken = (in_rs1 == in_rs2);
            OP_BNE:  taken = (in_rs1 != in_rs2);
            OP_BLT:  taken = ($signed(in_rs1) <  $signed(in_rs2));
            OP_BGE:  taken = ($signed(in_rs1) >= $signed(in_rs2));
            OP_BLTU: taken = (in_rs1 <  in_rs2);
            OP_BGEU: taken = (in_rs1 >= in_rs2);
            default: begin
                taken   = 1'b0;
                illegal = 1'b1;
            end
        endcase
        target     = taken ? (in_pc + in_imm) : (in_pc + XLEN'(4));
        misaligned = taken && (target[1:0] != 2'b00);
        mispredict = !illegal && (taken ^ in_pred_taken);
    end

    assign in_ready = (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Data fields load only on accept, so they stay frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_taken      <= 1'b0;
            out_mispredict <= 1'b0;
            out_illegal    <= 1'b0;
            out_misaligned <= 1'b0;
            out_target     <= '0;
        end else if (accept) begin
            out_taken      <= taken;
            out_mispredict <= mispredict;
            out_illegal    <= illegal;
            out_misaligned <= misaligned;
            out_target     <= target;
        end
    end

`ifdef BRANCH_STATS_EN
    // A handshake in a flush cycle still counts: the consumer took it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches   <= '0;
            stat_taken      <= '0;
            stat_mispredict <= '0;
        end else if (deliver) begin
            stat_branches <= stat_branches + 32'd1;
            if (out_taken && !out_illegal) begin
                stat_taken <= stat_taken + 32'd1;
            end
            if (out_mispredict && !out_illegal) begin
                stat_mispredict <= stat_mispredict + 32'd1;
            end
        end
    end
`else
    logic unused_deliver;
    assign unused_deliver = deliver;
`endif

endmodule

// File: doc/branch_resolve_pipe.md
BRANCH_RESOLVE_PIPE -- requirements
Module: branch_resolve_pipe

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, giving the operand, PC and immediate width (legal range 8..64).
REQ-002 The module SHALL have parameter OPW, default 5, giving the branch opcode width (minimum 3).
REQ-003 The module SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  a branch request is presented.
REQ-007 in_ready  output  1  the block accepts a request this cycle.
REQ-008 in_opcode  input  OPW  branch condition code.
REQ-009 in_rs1, in_rs2  input  XLEN each  compare operands.
REQ-010 in_pc, in_imm  input  XLEN each  branch PC and sign-extended offset.
REQ-011 in_pred_taken  input  1  front-end prediction for this branch.
REQ-012 flush  input  1  discards held and incoming requests.
REQ-013 out_valid  output  1  a result is held.
REQ-014 out_ready  input  1  the consumer takes the result.
REQ-015 out_taken, out_mispredict, out_illegal, out_misaligned  output  1 each  resolved flags.
REQ-016 out_target  output  XLEN  next PC.

Function
REQ-017 Decode: 00000 BEQ; 00001 BNE; 00100 BLT signed; 00101 BGE signed; 00110 BLTU unsigned; 00111 BGEU unsigned.
REQ-018 Any other opcode SHALL set out_illegal=1, out_taken=0 and out_target=pc+4.
REQ-019 Every decoded path SHALL assign taken explicitly; no latch or held value from a previous request is permitted.
REQ-020 out_target SHALL be pc+imm when taken, else pc+4, both modulo 2^XLEN, so wrap-around is silent.
REQ-021 out_misaligned SHALL be 1 only when taken and target[1:0] != 0.
REQ-022 out_mispredict SHALL equal taken XOR in_pred_taken; it SHALL be 0 when illegal.
REQ-023 The block SHALL hold a single output register with a latency of 1 cycle from the accept edge to out_valid.
REQ-024 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-025 Accept SHALL occur on in_valid && in_ready; the output register loads on that edge.
REQ-026 With out_valid=1 and out_ready=0, all outputs SHALL stay stable.
REQ-027 Simultaneous output handshake and accept SHALL replace the result back-to-back with no bubble, sustaining 1 result per cycle.
REQ-028 On flush=1, out_valid SHALL clear at the next edge and no request is accepted that cycle.
REQ-029 An output handshake coinciding with flush SHALL still count as delivered.
REQ-030 Output data fields SHALL be don't-care while out_valid=0, but SHALL never be X after reset.

Reset
REQ-031 While rst_n=0, out_valid, out_taken, out_mispredict, out_illegal and out_misaligned SHALL be 0 and out_target SHALL be 0, asynchronously.
REQ-032 Reset asserted mid-stall SHALL drop the held result.
REQ-033 After rst_n deasserts, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-034 With macro BRANCH_STATS_EN defined, the block SHALL add outputs stat_branches, stat_taken and stat_mispredict, each 32 bits, counting delivered results (output handshakes).
REQ-035 The counters SHALL reset to 0, wrap at 2^32, and exclude illegal results from stat_taken and stat_mispredict.
REQ-036 Without BRANCH_STATS_EN, these ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Verification
REQ-037 BLT with rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> taken=1, target=0x120; the same operands with BLTU -> taken=0, target=0x104.
REQ-038 BEQ with equal operands, then BNE with equal operands back-to-back, out_ready=1 -> results on consecutive cycles, taken 1 then 0, no bubble.
REQ-039 opcode 00010 after a taken BEQ -> out_illegal=1, out_taken=0, mispredict=0; the prior taken value does not persist.
REQ-040 pc=0xFFFFFFF0, imm=0x20, BGEU 5>=5 -> target=0x00000010 (wrap); with imm=0x22 -> out_misaligned=1.
REQ-041 Stall with out_ready=0 for 3 cycles, then flush -> outputs stable during the stall, in_ready=0, out_valid=0 after the flush edge; rst_n pulse mid-stall -> all outputs 0 immediately.
REQ-042 BRANCH_STATS_EN, 5 delivered branches (3 taken, 1 mispredict, 1 illegal) -> stat_branches=5, stat_taken=3, stat_mispredict=1.
